// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bus bridge: window base, register offsets
// and status bit positions.
package mmio_pkg;

  // Default base of the 256-byte MMIO window (only bits [31:8] are decoded).
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_7F00;

  // Register byte offsets inside the window.
  localparam logic [7:0] OFS_TX_DATA = 8'h00;
  localparam logic [7:0] OFS_TX_STAT = 8'h04;
  localparam logic [7:0] OFS_RX_DATA = 8'h08;
  localparam logic [7:0] OFS_RX_STAT = 8'h0C;
  localparam logic [7:0] OFS_CYCLE   = 8'h10;
  localparam logic [7:0] OFS_LED     = 8'h14;

  // TX_STAT layout.
  localparam int TX_STAT_FULL_BIT    = 0;
  localparam int TX_STAT_OVF_BIT     = 1;
  localparam int TX_STAT_CNT_LSB     = 8;

  // RX_STAT layout.
  localparam int RX_STAT_VALID_BIT   = 0;
  localparam int RX_STAT_OVERRUN_BIT = 1;

  // Word-granular offset compare; byte lanes addr[1:0] are ignored.
  function automatic logic ofs_match(input logic [7:0] addr_ofs, input logic [7:0] reg_ofs);
    return addr_ofs[7:2] == reg_ofs[7:2];
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO feeding the PDU transmit handshake. The head byte is
// presented combinationally so a pop at edge N shows the next byte in the
// following cycle. A push into a full FIFO is accepted only when a pop frees
// a slot in the same cycle; otherwise it is dropped (caller flags overflow).
module tx_byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  push_en;
  logic                  pop_en;

  assign full    = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign head    = empty ? 8'h00 : mem[rd_ptr_reg];

  // Storage write; contents need no reset because head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy update; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_reg <= count_reg - (DEPTH_LOG2 + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// MEM-stage bus bridge: routes CPU data accesses either to data memory or to
// the MMIO register window (TX FIFO, RX mailbox, LED, cycle counter).
// Reads are combinational so the CPU captures them in the same cycle.
// Build option: define MMIO_CYCLE_CNT_EN to include the CYCLE counter;
// without it there are no counter flops and offset 0x10 reads 0.
module mmio_bus_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEFAULT,
  parameter int          TXQ_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_mem_addr,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_din,
  output logic [31:0] cpu_mem_dout,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid_in,
  input  logic [31:0] rx_data_in,
  output logic [15:0] led
);

  logic                    mmio_hit;
  logic [7:0]              ofs;
  logic                    mmio_we;
  logic                    tx_push;
  logic                    tx_pop;
  logic                    tx_full;
  logic                    tx_empty;
  logic [TXQ_DEPTH_LOG2:0] tx_count;
  logic [7:0]              tx_count_byte;
  logic                    ovf_reg;
  logic                    tx_stat_wr;
  logic                    rx_ack;
  logic [31:0]             rx_data_reg;
  logic                    rx_valid_reg;
  logic                    rx_overrun_reg;
  logic [15:0]             led_reg;
  logic                    led_wr;
  logic [31:0]             cycle_val;
  logic [31:0]             mmio_rdata;

  // Address decode; data memory sees the raw bus, with writes gated by the window.
  assign mmio_hit = (cpu_mem_addr[31:8] == MMIO_BASE[31:8]);
  assign ofs      = cpu_mem_addr[7:0];
  assign mmio_we  = cpu_mem_we & mmio_hit;
  assign dm_addr  = cpu_mem_addr;
  assign dm_din   = cpu_mem_din;
  assign dm_we    = cpu_mem_we & ~mmio_hit;

  assign tx_push    = mmio_we & ofs_match(ofs, OFS_TX_DATA);
  assign tx_stat_wr = mmio_we & ofs_match(ofs, OFS_TX_STAT);
  assign rx_ack     = mmio_we & ofs_match(ofs, OFS_RX_STAT);
  assign led_wr     = mmio_we & ofs_match(ofs, OFS_LED);

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  tx_byte_fifo #(
    .DEPTH_LOG2 (TXQ_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (cpu_mem_din[7:0]),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (tx_data)
  );

  assign tx_count_byte = {{(7 - TXQ_DEPTH_LOG2){1'b0}}, tx_count};

  // Sticky overflow: set by a dropped push, cleared by any TX_STAT write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (tx_stat_wr) begin
      ovf_reg <= 1'b0;
    end else if (tx_push & tx_full & ~tx_pop) begin
      ovf_reg <= 1'b1;
    end
  end

  // RX mailbox: a new PDU word always wins over a coincident acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else if (rx_valid_in) begin
      rx_data_reg    <= rx_data_in;
      rx_valid_reg   <= 1'b1;
      rx_overrun_reg <= rx_ack ? 1'b0 : (rx_overrun_reg | rx_valid_reg);
    end else if (rx_ack) begin
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end
  end

  // LED register, low half-word of the store data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg <= '0;
    end else if (led_wr) begin
      led_reg <= cpu_mem_din[15:0];
    end
  end

  assign led = led_reg;

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cycle_reg;

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
    end
  end

  assign cycle_val = cycle_reg;
`else
  assign cycle_val = '0;
`endif

  // Register read mux; unmapped and write-only offsets read as zero.
  always_comb begin
    mmio_rdata = '0;
    case (ofs[7:2])
      OFS_TX_STAT[7:2]: begin
        mmio_rdata[TX_STAT_FULL_BIT]                       = tx_full;
        mmio_rdata[TX_STAT_OVF_BIT]                        = ovf_reg;
        mmio_rdata[TX_STAT_CNT_LSB +: 8]                   = tx_count_byte;
      end
      OFS_RX_DATA[7:2]: mmio_rdata = rx_data_reg;
      OFS_RX_STAT[7:2]: begin
        mmio_rdata[RX_STAT_VALID_BIT]   = rx_valid_reg;
        mmio_rdata[RX_STAT_OVERRUN_BIT] = rx_overrun_reg;
      end
      OFS_CYCLE[7:2]:   mmio_rdata = cycle_val;
      OFS_LED[7:2]:     mmio_rdata = {16'h0000, led_reg};
      default:          mmio_rdata = '0;
    endcase
  end

  // Return path to the CPU.
  always_comb begin
    cpu_mem_dout = dm_dout;
    if (mmio_hit) begin
      cpu_mem_dout = mmio_rdata;
    end
  end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Testbench for mmio_bus_bridge: a directed vector table (one vector per
// clock cycle, outputs compared before the edge that commits the inputs),
// followed by hand-written sequences for FIFO full/overflow, reset mid-drain
// and the cycle counter (behaviour depends on MMIO_CYCLE_CNT_EN).
module tb_mmio_bus_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_mem_addr;
  logic        cpu_mem_we;
  logic [31:0] cpu_mem_din;
  logic [31:0] cpu_mem_dout;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid_in;
  logic [31:0] rx_data_in;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;

  mmio_bus_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_mem_addr (cpu_mem_addr),
    .cpu_mem_we   (cpu_mem_we),
    .cpu_mem_din  (cpu_mem_din),
    .cpu_mem_dout (cpu_mem_dout),
    .dm_addr      (dm_addr),
    .dm_we        (dm_we),
    .dm_din       (dm_din),
    .dm_dout      (dm_dout),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .rx_valid_in  (rx_valid_in),
    .rx_data_in   (rx_data_in),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small behavioural data memory (word-indexed by addr[9:2]).
  logic [31:0] bench_mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) bench_mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (dm_we) bench_mem[dm_addr[9:2]] <= dm_din;
  end
  assign dm_dout = bench_mem[dm_addr[9:2]];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic        rdy;
    logic        rxv;
    logic [31:0] rxd;
    logic [31:0] exp_dout;
    logic        exp_dm_we;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [31:0] din,
                              input logic rdy, input logic rxv, input logic [31:0] rxd,
                              input logic [31:0] exp_dout, input logic exp_dm_we,
                              input logic exp_txv, input logic [7:0] exp_txd,
                              input logic [15:0] exp_led);
    vec_t v;
    v.addr = addr; v.we = we; v.din = din; v.rdy = rdy; v.rxv = rxv; v.rxd = rxd;
    v.exp_dout = exp_dout; v.exp_dm_we = exp_dm_we; v.exp_txv = exp_txv;
    v.exp_txd = exp_txd; v.exp_led = exp_led;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic we, input logic [31:0] din,
                       input logic rdy, input logic rxv, input logic [31:0] rxd);
    cpu_mem_addr = addr;
    cpu_mem_we   = we;
    cpu_mem_din  = din;
    tx_ready     = rdy;
    rx_valid_in  = rxv;
    rx_data_in   = rxd;
  endtask

  // Read a register combinationally within the current low clock phase.
  task automatic peek(input string name, input logic [31:0] addr, input logic [31:0] exp);
    drive(addr, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check32(name, cpu_mem_dout, exp);
    $display("peek %-12s addr=0x%08h dout=0x%08h", name, addr, cpu_mem_dout);
  endtask

  initial begin
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;

    // Vector table: expectations reflect state before the committing edge.
    //          addr          we   din            rdy  rxv  rxd           dout          dmwe txv  txd    led
    vecs.push_back(mk(32'h0000_0100, 1, 32'h0000_1234, 0, 0, 32'h0,        32'h0,        1, 0, 8'h00, 16'h0));
    vecs.push_back(mk(32'h0000_0100, 0, 32'h0,        0, 0, 32'h0,        32'h0000_1234, 0, 0, 8'h00, 16'h0));
    vecs.push_back(mk(32'h0000_7F04, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'h0));
    vecs.push_back(mk(32'h0000_7F0C, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'h0));
    vecs.push_back(mk(32'h0000_7F00, 1, 32'h0000_0041, 0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'h0));
    vecs.push_back(mk(32'h0000_7F00, 1, 32'h0000_0042, 0, 0, 32'h0,        32'h0,        0, 1, 8'h41, 16'h0));
    vecs.push_back(mk(32'h0000_7F04, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0200, 0, 1, 8'h41, 16'h0));
    vecs.push_back(mk(32'h0000_7F04, 0, 32'h0,        1, 0, 32'h0,        32'h0000_0200, 0, 1, 8'h41, 16'h0));
    vecs.push_back(mk(32'h0000_7F04, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0100, 0, 1, 8'h42, 16'h0));
    vecs.push_back(mk(32'h0000_7F04, 0, 32'h0,        1, 0, 32'h0,        32'h0000_0100, 0, 1, 8'h42, 16'h0));
    vecs.push_back(mk(32'h0000_7F04, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'h0));
    vecs.push_back(mk(32'h0000_7F14, 1, 32'hFFFF_A5A5, 0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'h0));
    vecs.push_back(mk(32'h0000_7F14, 0, 32'h0,        0, 0, 32'h0,        32'h0000_A5A5, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F0C, 0, 32'h0,        0, 1, 32'hDEAD_BEEF, 32'h0,        0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F08, 0, 32'h0,        0, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F0C, 0, 32'h0,        0, 1, 32'h0000_0005, 32'h0000_0001, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F0C, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0003, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F08, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0005, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F0C, 1, 32'h0,        0, 1, 32'h0000_0077, 32'h0000_0003, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F0C, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0001, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F08, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0077, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F0C, 1, 32'h0,        0, 0, 32'h0,        32'h0000_0001, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F0C, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F20, 1, 32'h1234_5678, 0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7F80, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7E00, 1, 32'h0000_CAFE, 0, 0, 32'h0,        32'h0,        1, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_7E00, 0, 32'h0,        0, 0, 32'h0,        32'h0000_CAFE, 0, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_8000, 1, 32'h0000_BEEF, 0, 0, 32'h0,        32'h0,        1, 0, 8'h00, 16'hA5A5));
    vecs.push_back(mk(32'h0000_0100, 0, 32'h0,        0, 0, 32'h0,        32'h0000_1234, 0, 0, 8'h00, 16'hA5A5));

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check32("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check32("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check32("rst_led", {16'h0, led}, 32'h0);
    peek("rst_tx_stat", 32'h0000_7F04, 32'h0);

    // Table-driven phase.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].rdy, vecs[i].rxv, vecs[i].rxd);
      #2;
      $display("vec %0d addr=0x%08h we=%0b din=0x%08h dout=0x%08h dm_we=%0b txv=%0b txd=0x%02h led=0x%04h",
               i, vecs[i].addr, vecs[i].we, vecs[i].din, cpu_mem_dout, dm_we, tx_valid, tx_data, led);
      check32($sformatf("v%0d_dout", i), cpu_mem_dout, vecs[i].exp_dout);
      check32($sformatf("v%0d_dm_we", i), {31'h0, dm_we}, {31'h0, vecs[i].exp_dm_we});
      check32($sformatf("v%0d_txv", i), {31'h0, tx_valid}, {31'h0, vecs[i].exp_txv});
      check32($sformatf("v%0d_txd", i), {24'h0, tx_data}, {24'h0, vecs[i].exp_txd});
      check32($sformatf("v%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end

    // FIFO fill, overflow, clear, then push+pop while full.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(32'h0000_7F00, 1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 32'h0);
      $display("push 0x%02h", 8'h10 + 8'(i));
      if (i == 8) begin
        #1;
        check32("full_before_9th", cpu_mem_dout, 32'h0);
      end
    end
    @(negedge clk);
    peek("stat_ovf", 32'h0000_7F04, 32'h0000_0803);
    check32("head_after_fill", {24'h0, tx_data}, 32'h10);
    @(negedge clk);
    drive(32'h0000_7F04, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    peek("stat_ovf_clr", 32'h0000_7F04, 32'h0000_0801);
    @(negedge clk);
    drive(32'h0000_7F00, 1'b1, 32'h19, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    peek("stat_push_pop", 32'h0000_7F04, 32'h0000_0801);
    begin
      logic [7:0] exp_seq [8];
      for (int i = 0; i < 7; i++) exp_seq[i] = 8'h11 + 8'(i);
      exp_seq[7] = 8'h19;
      for (int i = 0; i < 8; i++) begin
        drive(32'h0000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        $display("drain %0d txv=%0b txd=0x%02h", i, tx_valid, tx_data);
        check32($sformatf("drain%0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, exp_seq[i]});
        @(negedge clk);
      end
    end
    drive(32'h0000_7F04, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check32("drained", {23'h0, tx_valid, tx_data}, 32'h0);

    // Reset mid-drain: load three bytes and an RX word, start draining, then reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(32'h0000_7F00, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1, 32'h0000_3333);
    end
    @(negedge clk);
    drive(32'h0000_0100, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    $display("reset mid-drain txv=%0b txd=0x%02h led=0x%04h dm_we=%0b", tx_valid, tx_data, led, dm_we);
    check32("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check32("arst_tx_data", {24'h0, tx_data}, 32'h0);
    check32("arst_led", {16'h0, led}, 32'h0);
    check32("arst_dm_we", {31'h0, dm_we}, 32'h1);
    @(negedge clk);
    drive(32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    peek("cycle_after_rst", 32'h0000_7F10, 32'h0);
    peek("rx_stat_rst", 32'h0000_7F0C, 32'h0);
    peek("rx_data_rst", 32'h0000_7F08, 32'h0);
    peek("tx_stat_rst", 32'h0000_7F04, 32'h0);
    @(negedge clk);
`ifdef MMIO_CYCLE_CNT_EN
    peek("cycle_plus1", 32'h0000_7F10, 32'h1);
    repeat (100) @(negedge clk);
    peek("cycle_plus101", 32'h0000_7F10, 32'd101);
`else
    peek("cycle_plus1", 32'h0000_7F10, 32'h0);
    repeat (100) @(negedge clk);
    peek("cycle_plus101", 32'h0000_7F10, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
